// File: rtl/oam_dma_controller.sv
// CPU/memory bus controller with sprite (OAM) DMA.
// Passes CPU cycles through and stalls the CPU while it copies one page to OAM.
module oam_dma_controller #(
   parameter logic [15:0] DMA_REGISTER_ADDRESS = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDRESS     = 16'h2004
) (
   input  logic        clock_i,
   input  logic        reset_ni,
   input  logic        tick_i,
   input  logic [15:0] cpu_address_i,
   input  logic        cpu_address_valid_i,
   input  logic        cpu_write_i,
   input  logic [7:0]  cpu_data_i,
   output logic [7:0]  cpu_data_o,
   output logic        cpu_data_valid_o,
   output logic        dma_active_o,
   output logic [15:0] mem_address_o,
   output logic        mem_request_o,
   output logic        mem_write_o,
   output logic [7:0]  mem_data_o,
   input  logic [7:0]  mem_data_i,
   input  logic        mem_data_valid_i
);

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] index_q, index_d;
   logic [7:0] buffer_q, buffer_d;
   logic       parity_q;
   logic       trigger;

   assign trigger = cpu_address_valid_i & cpu_write_i
                  & (cpu_address_i == DMA_REGISTER_ADDRESS);

   assign dma_active_o = (state_q != IDLE);

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= IDLE;
         page_q   <= 8'h00;
         index_q  <= 8'h00;
         buffer_q <= 8'h00;
         parity_q <= 1'b0;
      end else if (tick_i) begin
         state_q  <= state_d;
         page_q   <= page_d;
         index_q  <= index_d;
         buffer_q <= buffer_d;
         parity_q <= ~parity_q;
      end
   end

   always_comb begin
      state_d          = state_q;
      page_d           = page_q;
      index_d          = index_q;
      buffer_d         = buffer_q;
      cpu_data_o       = 8'h00;
      cpu_data_valid_o = 1'b0;
      mem_address_o    = 16'h0000;
      mem_request_o    = 1'b0;
      mem_write_o      = 1'b0;
      mem_data_o       = 8'h00;

      unique case (state_q)
         IDLE: begin
            mem_address_o = cpu_address_i;
            mem_write_o   = cpu_write_i;
            mem_data_o    = cpu_data_i;
            cpu_data_o    = mem_data_i;
            if (trigger) begin
               // The DMA register lives here; the write never reaches the bus.
               cpu_data_valid_o = tick_i;
               page_d           = cpu_data_i;
               index_d          = 8'h00;
               state_d          = HALT;
            end else begin
               mem_request_o    = cpu_address_valid_i;
               cpu_data_valid_o = mem_data_valid_i;
            end
         end
         HALT: begin
            state_d = parity_q ? ALIGN : READ;
         end
         ALIGN: begin
            state_d = READ;
         end
         READ: begin
            mem_address_o = {page_q, index_q};
            mem_request_o = 1'b1;
            if (mem_data_valid_i) begin
               buffer_d = mem_data_i;
               state_d  = WRITE;
            end
         end
         WRITE: begin
            mem_address_o = OAM_DATA_ADDRESS;
            mem_request_o = 1'b1;
            mem_write_o   = 1'b1;
            mem_data_o    = buffer_q;
            if (mem_data_valid_i) begin
               index_d = index_q + 8'd1;
               state_d = (index_q == 8'hFF) ? IDLE : READ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Keep the bus and CPU quiet for as long as reset is held.
      if (!reset_ni) begin
         mem_request_o    = 1'b0;
         cpu_data_valid_o = 1'b0;
      end
   end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller.
// Ticks are one cycle in two; memory contents come from a fixed formula.
module tb_oam_dma_controller;

   logic        clock_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        tick_i = 1'b0;
   logic [15:0] cpu_address_i = 16'h0000;
   logic        cpu_address_valid_i = 1'b0;
   logic        cpu_write_i = 1'b0;
   logic [7:0]  cpu_data_i = 8'h00;
   logic [7:0]  cpu_data_o;
   logic        cpu_data_valid_o;
   logic        dma_active_o;
   logic [15:0] mem_address_o;
   logic        mem_request_o;
   logic        mem_write_o;
   logic [7:0]  mem_data_o;
   logic [7:0]  mem_data_i;
   logic        mem_data_valid_i = 1'b0;

   logic        override_en = 1'b0;
   logic [7:0]  override_val = 8'h00;
   int          passed = 0;
   int          total = 0;
   int          gtick = 0;

   oam_dma_controller dut (
      .clock_i            (clock_i),
      .reset_ni           (reset_ni),
      .tick_i             (tick_i),
      .cpu_address_i      (cpu_address_i),
      .cpu_address_valid_i(cpu_address_valid_i),
      .cpu_write_i        (cpu_write_i),
      .cpu_data_i         (cpu_data_i),
      .cpu_data_o         (cpu_data_o),
      .cpu_data_valid_o   (cpu_data_valid_o),
      .dma_active_o       (dma_active_o),
      .mem_address_o      (mem_address_o),
      .mem_request_o      (mem_request_o),
      .mem_write_o        (mem_write_o),
      .mem_data_o         (mem_data_o),
      .mem_data_i         (mem_data_i),
      .mem_data_valid_i   (mem_data_valid_i)
   );

   always #5 clock_i = ~clock_i;

   function automatic logic [7:0] memval(input logic [15:0] a);
      return a[7:0] ^ (a[15:8] - 8'h02);
   endfunction

   always_comb begin
      mem_data_i = override_en ? override_val : memval(mem_address_o);
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic cpu_set(input logic v, input logic w,
                          input logic [15:0] a, input logic [7:0] d);
      cpu_address_valid_i = v;
      cpu_write_i         = w;
      cpu_address_i       = a;
      cpu_data_i          = d;
   endtask

   task automatic tick_edge();
      @(posedge clock_i);
      #1;
      gtick++;
      tick_i = 1'b0;
      @(posedge clock_i);
      #1;
   endtask

   task automatic idle_tick();
      cpu_set(1'b0, 1'b0, 16'h0000, 8'h00);
      mem_data_valid_i = 1'b1;
      tick_i = 1'b1;
      #1;
      tick_edge();
   endtask

   task automatic align_to(input int odd);
      while ((gtick % 2) != odd) idle_tick();
   endtask

   task automatic passthrough_read(input string tag);
      override_en  = 1'b1;
      override_val = 8'h5A;
      mem_data_valid_i = 1'b1;
      cpu_set(1'b1, 1'b0, 16'h8000, 8'h00);
      tick_i = 1'b1;
      #1;
      check({tag, ".addr"}, mem_address_o, 16'h8000);
      check({tag, ".req"}, mem_request_o, 1);
      check({tag, ".rdata"}, cpu_data_o, 8'h5A);
      check({tag, ".valid"}, cpu_data_valid_o, 1);
      tick_edge();
      override_en = 1'b0;
      cpu_set(1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic run_dma(input string tag, input logic [7:0] page,
                          input int waitidx, input int waitn,
                          input bit inject, input int abort_idx);
      int ticks = 0;
      int nwr = 0;
      int nrd = 0;
      int badaddr = 0;
      int baddata = 0;
      int badcpu = 0;
      int waits_left = waitn;
      int exp_len;
      bit rd;
      bit stopped = 0;
      logic [15:0] lastrd = 16'h0000;

      exp_len = 513 + (((gtick % 2) == 0) ? 1 : 0) + waitn;
      mem_data_valid_i = 1'b1;
      cpu_set(1'b1, 1'b1, 16'h4014, page);
      tick_i = 1'b1;
      #1;
      check({tag, ".trig_req"}, mem_request_o, 0);
      check({tag, ".trig_valid"}, cpu_data_valid_o, 1);
      tick_edge();
      cpu_set(1'b1, 1'b0, 16'h8000, 8'h00);
      check({tag, ".active_rise"}, dma_active_o, 1);

      while (dma_active_o && ticks < 2000) begin
         tick_i = 1'b1;
         if (inject && ticks >= 50 && ticks < 60)
            cpu_set(1'b1, 1'b1, 16'h4014, 8'h55);
         else
            cpu_set(1'b1, 1'b0, 16'h8000, 8'h00);
         #1;
         rd = mem_request_o && !mem_write_o;
         mem_data_valid_i = 1'b1;
         if (rd && nrd == waitidx && waits_left > 0) begin
            mem_data_valid_i = 1'b0;
            waits_left--;
         end
         if (abort_idx >= 0 && rd && nrd == abort_idx) begin
            reset_ni = 1'b0;
            #1;
            check({tag, ".abort_req"}, mem_request_o, 0);
            check({tag, ".abort_active"}, dma_active_o, 0);
            check({tag, ".abort_cvalid"}, cpu_data_valid_o, 0);
            stopped = 1;
            break;
         end
         #1;
         if (cpu_data_valid_o !== 1'b0 || cpu_data_o !== 8'h00) badcpu++;
         if (rd && !mem_data_valid_i
             && mem_address_o !== {page, nrd[7:0]}) badaddr++;
         if (mem_request_o && mem_data_valid_i) begin
            if (mem_write_o) begin
               if (mem_address_o !== 16'h2004) badaddr++;
               if (nwr != nrd - 1) badaddr++;
               if (mem_data_o !== memval({page, nwr[7:0]})) baddata++;
               nwr++;
            end else begin
               if (mem_address_o !== {page, nrd[7:0]}) badaddr++;
               lastrd = mem_address_o;
               nrd++;
            end
         end
         tick_edge();
         ticks++;
      end

      if (stopped) begin
         tick_i = 1'b0;
         cpu_set(1'b0, 1'b0, 16'h0000, 8'h00);
         #10;
         check({tag, ".held_req"}, mem_request_o, 0);
         reset_ni = 1'b1;
         gtick = 0;
         @(posedge clock_i);
         #1;
      end else begin
         check({tag, ".len"}, ticks, exp_len);
         check({tag, ".writes"}, nwr, 256);
         check({tag, ".reads"}, nrd, 256);
         check({tag, ".badaddr"}, badaddr, 0);
         check({tag, ".baddata"}, baddata, 0);
         check({tag, ".badcpu"}, badcpu, 0);
         check({tag, ".lastrd"}, lastrd, {page, 8'hFF});
         check({tag, ".active_fall"}, dma_active_o, 0);
         tick_i = 1'b1;
         mem_data_valid_i = 1'b1;
         #1;
         check({tag, ".resume_addr"}, mem_address_o, 16'h8000);
         check({tag, ".resume_req"}, mem_request_o, 1);
         check({tag, ".resume_valid"}, cpu_data_valid_o, 1);
         tick_edge();
         cpu_set(1'b0, 1'b0, 16'h0000, 8'h00);
      end
   endtask

   initial begin
      cpu_set(1'b1, 1'b0, 16'h8000, 8'h00);
      mem_data_valid_i = 1'b1;
      #2;
      check("rst.req", mem_request_o, 0);
      check("rst.cvalid", cpu_data_valid_o, 0);
      check("rst.active", dma_active_o, 0);
      #20;
      reset_ni = 1'b1;
      gtick = 0;
      @(posedge clock_i);
      #1;

      passthrough_read("pass_rd");
      cpu_set(1'b1, 1'b1, 16'h1234, 8'h77);
      mem_data_valid_i = 1'b0;
      tick_i = 1'b1;
      #1;
      check("pass_wr.data", mem_data_o, 8'h77);
      check("pass_wr.we", mem_write_o, 1);
      check("pass_wr.addr", mem_address_o, 16'h1234);
      check("pass_wr.cvalid", cpu_data_valid_o, 0);
      tick_edge();

      align_to(0);
      run_dma("dma_even", 8'h02, -1, 0, 0, -1);
      align_to(1);
      run_dma("dma_odd", 8'h03, -1, 0, 0, -1);
      align_to(0);
      run_dma("dma_wait", 8'h02, 10, 3, 1, -1);
      align_to(1);
      run_dma("dma_wrap", 8'hFF, -1, 0, 0, -1);
      run_dma("dma_abort", 8'h02, -1, 0, 0, 100);
      passthrough_read("post_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
